rom_cell_fetch: RTL and testbench
=================================

Name: rom_cell_fetch

Overview:
Sequences the synchronous boot/constant ROM so multiple requesters can read two-word tagged cells: header word at base, value word at base+1. Arbitrates round-robin between NUM_REQ requesters over valid/ready handshakes. Issues two back-to-back ROM reads that respect the ROM's 1-cycle registered read latency, and returns header and value together. Sits between the ROM instance and its clients: the evaluator's constant fetch and the image loader.

Parameters:
ADDR_WIDTH, 8, ROM address width; must match the ROM instance.
DATA_WIDTH, 16, ROM word width; header and value are each one word.
NUM_REQ, 2, number of requesters (2..8).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester fetch request
req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester base address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  output  NUM_REQ  one-hot or zero; high for the requester accepted this cycle
rsp_valid  output  NUM_REQ  one-hot or zero; response valid for the owning requester
rsp_ready  input  NUM_REQ  per-requester response accept
rsp_hdr  output  DATA_WIDTH  header word, shared by all requesters and qualified by rsp_valid
rsp_val  output  DATA_WIDTH  value word, shared by all requesters
rsp_err  output  1  fetch refused (cell crosses the top of ROM)
rom_addr  output  ADDR_WIDTH  registered address to ROM.addr
rom_data  input  DATA_WIDTH  ROM.data_out; valid the cycle after rom_addr changes
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: rom_addr=0, rsp_valid=0, rsp_hdr=0, rsp_val=0, rsp_err=0, busy=0, state=IDLE, rr pointer=0.
- Reset applied mid-operation returns to IDLE at the next edge. The in-flight fetch is dropped and no response is produced.
- Handshake: a transfer occurs on an edge where req_valid[i] & req_ready[i] is high.
- req_ready is combinational, and is high only in IDLE for the single arbitration winner.
- req_addr is sampled only at the accept edge.
- Arbitration is round-robin. Search starts at pointer p, then p+1, ..., wrapping modulo NUM_REQ.
- After a response to requester i completes, p becomes (i+1) mod NUM_REQ.
- FSM states, with accept at edge t:
  - IDLE: on accept of requester i, latch owner=i and base.
    - base != 2^ADDR_WIDTH-1: rom_addr<=base; go to ISSUE_VAL.
    - base == 2^ADDR_WIDTH-1: go to RESP with rsp_err=1 and rsp_hdr/rsp_val=0. No ROM address is issued.
  - ISSUE_VAL: rom_addr<=base+1; go to CAP_HDR.
  - CAP_HDR: rsp_hdr<=rom_data (word at base); go to CAP_VAL.
  - CAP_VAL: rsp_val<=rom_data (word at base+1), rsp_err<=0; go to RESP.
  - RESP: rsp_valid[owner]=1, and rsp_hdr/rsp_val/rsp_err are held stable.
    - On rsp_ready[owner], go to IDLE and update the pointer.
    - rsp_ready of non-owners is ignored.
- Latency:
  - Normal fetch: rsp_valid is first high in cycle t+4.
  - Error fetch: rsp_valid is first high in cycle t+1.
  - If rsp_ready is held high, the next accept occurs in the cycle after the response cycle, so the minimum period is 5 cycles.
- Only one fetch is outstanding at a time, with no pipelining across requests.
- While not in IDLE, every req_ready is 0 and pending requests simply wait.
- Simultaneous requests from all requesters are served in round-robin order; none starves.
- rom_addr keeps its last value when idle.
- The header is forwarded unmodified. Tag decode is the consumer's job.

Decomposition:
- Add to package lisp:
  - typedef enum rom_fetch_state_t {IDLE, ISSUE_VAL, CAP_HDR, CAP_VAL, RESP};
  - localparam ROM_READ_LATENCY = 1;
  - localparam CELL_WORDS = 2.
- Sub-module rr_arbiter (parameter N) contains the priority pointer.
  - Inputs: req vector, advance strobe, advance index.
  - Output: one-hot grant.

Test Plan:
- ROM[0x0]={1'b0,TYPE_NUMBER}, ROM[0x1]=16'h2A2A. Requester 0 fetches 0x0 with rsp_ready=1 -> rsp_valid[0] in cycle t+4, rsp_hdr={1'b0,TYPE_NUMBER}, rsp_val=16'h2A2A, rsp_err=0; rom_addr sequence 0x0 then 0x1.
- Both requesters hold req_valid continuously, addresses 0x0 and 0x10 -> grants alternate 0,1,0,1; each response carries the correct owner's data.
- Requester 1 fetches 0xFF with ADDR_WIDTH=8 -> rsp_valid[1] at t+1, rsp_err=1, hdr/val=0, no change to rom_addr.
- Backpressure: rsp_ready[0]=0 for 6 cycles -> rsp_valid, hdr and val are held stable and req_ready stays 0; a pending req from 1 is accepted the cycle after rsp_ready[0] rises.
- rst pulsed during CAP_HDR -> next cycle: IDLE, busy=0, all rsp_valid=0; no stale response afterwards.
- rsp_ready[1]=1 while requester 0 owns RESP -> the response is not consumed and the state stays RESP.

Source files
------------

// File: rtl/rom_cell_fetch_pkg.sv
// Shared types and constants for the two-word ROM cell fetcher.
package rom_cell_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE_VAL = 3'd1,
        CAP_HDR   = 3'd2,
        CAP_VAL   = 3'd3,
        RESP      = 3'd4
    } rom_fetch_state_t;

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_ISSUE_VAL = ISSUE_VAL;
    localparam logic [2:0] ST_CAP_HDR   = CAP_HDR;
    localparam logic [2:0] ST_CAP_VAL   = CAP_VAL;
    localparam logic [2:0] ST_RESP      = RESP;

    localparam int ROM_READ_LATENCY = 1;
    localparam int CELL_WORDS       = 2;

endpackage

// File: rtl/rom_cell_fetch_if.sv
// Requester-side bundle: per-requester request/response handshakes plus shared response data.
interface rom_cell_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_hdr;
    logic [DATA_WIDTH-1:0]         rsp_val;
    logic                          rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_hdr, rsp_val, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_hdr, rsp_val, rsp_err
    );
endinterface

// File: rtl/rom_cell_fetch_rr_arbiter.sv
// Round-robin arbiter: grant is combinational from the pointer; pointer moves past
// the served index when the advance strobe is seen.
module rom_cell_fetch_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic [IW-1:0] adv_idx_i,
    output logic [N-1:0]  gnt_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign ptr_d = (adv_idx_i == IW'(N-1)) ? '0 : adv_idx_i + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)        ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rom_cell_fetch.sv
// Fetches a {header, value} cell from a 1-cycle registered ROM for one of NUM_REQ requesters.
// One fetch in flight; response held until the owner accepts it.
module rom_cell_fetch
    import rom_cell_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rom_cell_fetch_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);
    // Highest base whose whole cell still fits below the top of the ROM.
    localparam logic [ADDR_WIDTH-1:0] LAST_BASE = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(CELL_WORDS - 1);

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  acc;
    logic                  rsp_done;

    rom_cell_fetch_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .adv_i     (rsp_done),
        .adv_idx_i (owner_q),
        .gnt_o     (gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win_idx = IW'(i);
        end
    end

    assign win_addr = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign acc      = (state_q == ST_IDLE) && (|gnt);
    assign rsp_done = (state_q == ST_RESP) && bus.rsp_ready[owner_q];

    assign bus.req_ready = acc ? gnt : '0;
    assign bus.rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.rsp_hdr   = hdr_q;
    assign bus.rsp_val   = val_q;
    assign bus.rsp_err   = err_q;
    assign rom_addr      = rom_addr_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        base_d     = base_q;
        rom_addr_d = rom_addr_q;
        hdr_d      = hdr_q;
        val_d      = val_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    owner_d = win_idx;
                    base_d  = win_addr;
                    if (win_addr > LAST_BASE) begin
                        // Refused cell: answer immediately without touching the ROM.
                        err_d   = 1'b1;
                        hdr_d   = '0;
                        val_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        rom_addr_d = win_addr;
                        state_d    = ST_ISSUE_VAL;
                    end
                end
            end
            ST_ISSUE_VAL: begin
                rom_addr_d = base_q + 1'b1;
                state_d    = ST_CAP_HDR;
            end
            ST_CAP_HDR: begin
                hdr_d   = rom_data;
                state_d = ST_CAP_VAL;
            end
            ST_CAP_VAL: begin
                val_d   = rom_data;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            base_q     <= '0;
            rom_addr_q <= '0;
            hdr_q      <= '0;
            val_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            rom_addr_q <= rom_addr_d;
            hdr_q      <= hdr_d;
            val_q      <= val_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_rom_cell_fetch.sv
// Bench for rom_cell_fetch: ROM model, cycle-level scoreboard monitor, vector table and corner sequences.
module tb_rom_cell_fetch;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam logic [14:0] TYPE_NUMBER = 15'h0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rom_cell_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    rom_cell_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= mem[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (p + k) % NR;
            if (v[j]) return NR'(1) << j;
        end
        return '0;
    endfunction

    typedef struct {
        int            owner;
        logic [AW-1:0] base;
        logic          err;
        logic [DW-1:0] hdr;
        logic [DW-1:0] val;
        int            cyc;
        int            lat;
        logic [AW-1:0] prev_rom;
    } exp_t;

    exp_t          sb [$];
    int            owner_log [$];
    int            acc_log [$];
    int            m_ptr = 0;
    bit            m_idle = 1'b1;
    int            acc_cnt = 0, n_rsp = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
    int            last_owner = 0, last_lat = 0;
    logic [DW-1:0] last_hdr, last_val;
    logic          last_err;

    always @(negedge clk) begin
        exp_t          e, n;
        logic [NR-1:0] exp_rdy, exp_v, acc_v;
        if (rst) begin
            sb.delete();
            m_idle = 1'b1;
            m_ptr  = 0;
        end else begin
            exp_rdy = m_idle ? pick(bus.req_valid, m_ptr) : '0;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(!m_idle));
            exp_v = '0;
            if (sb.size() > 0) begin
                e = sb[0];
                if (cyc == e.cyc + 1)
                    chk("rom_addr_first", 32'(rom_addr), 32'(e.err ? e.prev_rom : e.base));
                if (cyc == e.cyc + 2 && !e.err)
                    chk("rom_addr_second", 32'(rom_addr), 32'(e.base + 8'd1));
                if (cyc >= e.cyc + e.lat) exp_v = NR'(1) << e.owner;
            end
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            if (exp_v != '0) begin
                chk("rsp_hdr", 32'(bus.rsp_hdr), 32'(e.hdr));
                chk("rsp_val", 32'(bus.rsp_val), 32'(e.val));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                if (bus.rsp_ready[e.owner]) begin
                    void'(sb.pop_front());
                    m_idle       = 1'b1;
                    m_ptr        = (e.owner + 1) % NR;
                    last_owner   = e.owner;
                    last_hdr     = bus.rsp_hdr;
                    last_val     = bus.rsp_val;
                    last_err     = bus.rsp_err;
                    last_lat     = cyc - e.cyc;
                    last_rsp_cyc = cyc;
                    owner_log.push_back(e.owner);
                    n_rsp++;
                end
            end
            acc_v = bus.req_valid & bus.req_ready;
            if (acc_v != '0) begin
                n.owner = 0;
                for (int i = 0; i < NR; i++) if (acc_v[i]) n.owner = i;
                n.base     = bus.req_addr[n.owner*AW +: AW];
                n.err      = (n.base == 8'hFF);
                n.hdr      = n.err ? 16'h0 : mem[n.base];
                n.val      = n.err ? 16'h0 : mem[n.base + 8'd1];
                n.lat      = n.err ? 1 : 4;
                n.cyc      = cyc;
                n.prev_rom = rom_addr;
                sb.push_back(n);
                m_idle       = 1'b0;
                acc_cnt++;
                last_acc_cyc = cyc;
                acc_log.push_back(cyc);
            end
        end
    end

    task automatic wait_accept(input string nm);
        int a0;
        a0 = acc_cnt;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) return;
        end
        checks++; errors++;
        $display("FAIL %s: no accept within 30 cycles", nm);
    endtask

    task automatic wait_rsp(input string nm, input int n0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (n_rsp != n0) return;
        end
        checks++; errors++;
        $display("FAIL %s: no response within 30 cycles", nm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        int            r;
        logic [AW-1:0] a;
        logic [DW-1:0] hdr;
        logic [DW-1:0] val;
        logic          err;
        int            lat;
    } vec_t;

    vec_t          tbl [6];
    logic [DW-1:0] h, v;
    int            n0, vcnt;

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = {8'(a) ^ 8'h5A, 8'(a) + 8'h33};
        mem[0] = {1'b0, TYPE_NUMBER};
        mem[1] = 16'h2A2A;
        tbl[0] = '{0, 8'h00, {1'b0, TYPE_NUMBER}, 16'h2A2A, 1'b0, 4};
        tbl[1] = '{1, 8'h10, mem[8'h10], mem[8'h11], 1'b0, 4};
        tbl[2] = '{0, 8'hFE, mem[8'hFE], mem[8'hFF], 1'b0, 4};
        tbl[3] = '{1, 8'hFF, 16'h0, 16'h0, 1'b1, 1};
        tbl[4] = '{0, 8'hFF, 16'h0, 16'h0, 1'b1, 1};
        tbl[5] = '{1, 8'h01, mem[8'h01], mem[8'h02], 1'b0, 4};

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = '0;
        do_reset();
        @(negedge clk);
        chk("reset_rom_addr", 32'(rom_addr), 32'h0);
        chk("reset_hdr", 32'(bus.rsp_hdr), 32'h0);
        chk("reset_val", 32'(bus.rsp_val), 32'h0);
        chk("reset_err", 32'(bus.rsp_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.rsp_ready = '1;
            bus.req_addr[tbl[i].r*AW +: AW] = tbl[i].a;
            bus.req_valid[tbl[i].r] = 1'b1;
            n0 = n_rsp;
            wait_accept("tbl_accept");
            bus.req_valid = '0;
            wait_rsp("tbl_rsp", n0);
            chk("tbl_owner", 32'(last_owner), 32'(tbl[i].r));
            chk("tbl_hdr", 32'(last_hdr), 32'(tbl[i].hdr));
            chk("tbl_val", 32'(last_val), 32'(tbl[i].val));
            chk("tbl_err", 32'(last_err), 32'(tbl[i].err));
            chk("tbl_latency", 32'(last_lat), 32'(tbl[i].lat));
        end

        // Both requesters pending continuously: grants must alternate.
        do_reset();
        owner_log.delete();
        acc_log.delete();
        bus.req_addr  = {8'h10, 8'h00};
        bus.rsp_ready = '1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (owner_log.size() >= 4) break;
        end
        bus.req_valid = '0;
        if (owner_log.size() < 4) begin
            checks++; errors++;
            $display("FAIL rr_order: only %0d responses, required 4", owner_log.size());
        end else begin
            for (int k = 0; k < 4; k++) chk("rr_order", 32'(owner_log[k]), 32'(k % 2));
            chk("rr_period", 32'(acc_log[1] - acc_log[0]), 32'd5);
        end
        repeat (3) @(posedge clk); #1;

        // Backpressure on owner 0 with requester 1 pending; non-owner ready ignored.
        do_reset();
        bus.rsp_ready = '0;
        bus.req_addr  = {8'h30, 8'h20};
        bus.req_valid = 2'b01;
        wait_accept("bp_accept0");
        bus.req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid[0]) break;
        end
        h = bus.rsp_hdr;
        v = bus.rsp_val;
        chk("bp_hdr_value", 32'(h), 32'(mem[8'h20]));
        for (int k = 0; k < 6; k++) begin
            bus.rsp_ready = (k < 3) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_hdr_hold", 32'(bus.rsp_hdr), 32'(h));
            chk("bp_val_hold", 32'(bus.rsp_val), 32'(v));
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b01;
        wait_accept("bp_accept1");
        chk("bp_accept_timing", 32'(last_acc_cyc), 32'(last_rsp_cyc + 1));
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        n0 = n_rsp;
        wait_rsp("bp_rsp1", n0);
        chk("bp_owner1", 32'(last_owner), 32'h1);
        chk("bp_hdr1", 32'(last_hdr), 32'(mem[8'h30]));

        // Reset while capturing the header: fetch is dropped.
        do_reset();
        bus.rsp_ready = 2'b11;
        bus.req_addr  = {8'h00, 8'h40};
        bus.req_valid = 2'b01;
        wait_accept("rst_accept");
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) vcnt++;
        end
        chk("rst_no_stale", 32'(vcnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
